selevy_mem_arbiter: RTL and testbench
=====================================

# selevy_mem_arbiter

Two-requester arbiter that shares the single-port data RAM of the selevy core between the CPU load/store unit (port m0) and a debug/loader port (port m1). It serialises accesses with a three-state sequencer, applies round-robin priority when both ports request, and returns read data or write completion to the winning port. It sits between the core's memory stage and `selevy_ram`, which it drives through registered signals.

## Interface
- `DATA_W`, 32, RAM word width.
- `ADDR_W`, 8, RAM word-address width.

- `CLK`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `m0_req` / `m1_req`  in  1  access request, held until `mN_done`.
- `m0_we` / `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr` / `m1_addr`  in  ADDR_W  word address.
- `m0_wdata` / `m1_wdata`  in  DATA_W  write data.
- `m0_gnt` / `m1_gnt`  out  1  one-cycle grant, asserted in the ISSUE state.
- `m0_done` / `m1_done`  out  1  one-cycle completion, asserted in the DONE state.
- `rdata`  out  DATA_W  read data, shared by both ports; valid only with `mN_done` when the access is a read.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data, valid one cycle after `ram_en` with `ram_we`=0.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, DONE. There are no other states.
- **IDLE**
  - If no request is present, stay in IDLE.
  - If exactly one `mN_req` is high, select that port.
  - If both are high, select the port indicated by the priority bit `prio` (0 = m0, 1 = m1).
  - On selection: latch `sel`, `we`, `addr` and `wdata` from the selected port; next state is ISSUE.
- **ISSUE**
  - Drive `ram_en`=1, with `ram_we`, `ram_addr` and `ram_wdata` taken from the latched values.
  - Assert `m<sel>_gnt`=1.
  - Next state is DONE.
- **DONE**
  - Drive `ram_en`=0 and assert `m<sel>_done`=1.
  - `rdata` = `ram_rdata` (combinational pass-through) for reads; `rdata` = 0 for writes.
  - Set `prio` to the port that was not served (`prio` = ~`sel`).
  - Next state is IDLE.
- The requester latches nothing beyond its request. Operands are captured at selection, so request inputs may change after grant without effect.
- Requester protocol: deassert `mN_req` on the clock edge where `mN_done` is sampled high. A request still high in the following IDLE cycle is treated as a new access.
- Withdrawal: a `req` dropped before selection is simply not selected. No grant or done is produced for it.
- Outputs `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`, `mN_gnt` and `mN_done` are registered (state-decoded flops). `rdata` is the only combinational output.
- Fairness: with both ports requesting continuously, grants alternate m0, m1, m0, … and no port waits more than one foreign access.

## Timing
- Reset (asynchronous, immediate):
  - State → IDLE and `prio` → 0.
  - All outputs → 0: `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`, both `gnt`, both `done`, `rdata`, `busy`.
- Reset mid-access: the access is aborted and no `done` is issued. A write already strobed in ISSUE may have reached the RAM; the RAM contents are not restored.
- Latency: a request sampled high in IDLE at edge T gives `gnt` high in cycle T+1 and `done` high in cycle T+2. The next selection is possible at edge T+3.
- Throughput: at most one access per 3 cycles.
- Simultaneous requests at reset release: m0 wins (`prio`=0).
- `busy` = (state != IDLE) and is registered together with the state.

## Test plan
- Preload RAM[5] = 0xDEADBEEF; m0 read addr 5 → `m0_gnt` one cycle after request, then `m0_done` with `rdata` = 0xDEADBEEF; `m1_gnt` and `m1_done` stay 0.
- m1 write addr 3 data 0x12345678, then m0 read addr 3 → `m1_done` with `rdata` = 0; m0 read returns 0x12345678; `ram_we` is high only in m1's ISSUE cycle.
- m0 and m1 both hold `req` for 4 accesses each, re-raising after every `done` → grant order m0, m1, m0, m1, m0, m1, m0, m1; one access completes every 3 cycles.
- m0 requests back-to-back alone → m0 served on every access; `prio` toggles to 1 after each; `busy` low for exactly one cycle between accesses.
- Assert `reset` during ISSUE of an m0 read → all outputs 0 immediately; no `m0_done`; after release, a pending m1 request is served with first grant 1 cycle after IDLE.
- m1 raises `req` for one cycle while m0 is being served (ISSUE state), then drops it → m1 never granted; the arbiter returns to IDLE with `busy`=0.

Source files
------------

// File: rtl/selevy_mem_arbiter_if.sv
// Request/response and RAM-side signals of the selevy data-RAM arbiter.
// master = requesters plus RAM read path, slave = the arbiter.
interface selevy_mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              m0_req;
  logic              m1_req;
  logic              m0_we;
  logic              m1_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m1_wdata;
  logic              m0_gnt;
  logic              m1_gnt;
  logic              m0_done;
  logic              m1_done;
  logic [DATA_W-1:0] rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output ram_rdata,
    input  m0_gnt, m1_gnt, m0_done, m1_done, rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata, busy
  );

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  ram_rdata,
    output m0_gnt, m1_gnt, m0_done, m1_done, rdata,
    output ram_en, ram_we, ram_addr, ram_wdata, busy
  );
endinterface

// File: rtl/selevy_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the LSU (m0) and debug port (m1).
// One access per three cycles (IDLE -> ISSUE -> DONE); all outputs except rdata are registered.
module selevy_mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                 CLK,
  input  logic                 reset,
  selevy_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t            state_q;
  logic              prio_q;
  logic              sel_q;
  logic              we_q;
  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic              busy_q;
  logic              sel_d;

  // A lone requester wins outright; a tie goes to the port named by prio_q.
  always_comb begin
    sel_d = prio_q;
    if (bus.m0_req && !bus.m1_req) begin
      sel_d = 1'b0;
    end else if (!bus.m0_req && bus.m1_req) begin
      sel_d = 1'b1;
    end
  end

  // ram_addr_q/ram_wdata_q double as the operand latch for the access in flight.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            state_q     <= ISSUE;
            sel_q       <= sel_d;
            we_q        <= sel_d ? bus.m1_we : bus.m0_we;
            ram_en_q    <= 1'b1;
            ram_we_q    <= sel_d ? bus.m1_we : bus.m0_we;
            ram_addr_q  <= sel_d ? bus.m1_addr : bus.m0_addr;
            ram_wdata_q <= sel_d ? bus.m1_wdata : bus.m0_wdata;
            gnt_q       <= sel_d ? 2'b10 : 2'b01;
            busy_q      <= 1'b1;
          end
        end
        ISSUE: begin
          state_q  <= DONE;
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          gnt_q    <= 2'b00;
          done_q   <= sel_q ? 2'b10 : 2'b01;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 2'b00;
          busy_q  <= 1'b0;
          prio_q  <= ~sel_q;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata     = (state_q == DONE && !we_q) ? bus.ram_rdata : '0;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.m0_gnt    = gnt_q[0];
  assign bus.m1_gnt    = gnt_q[1];
  assign bus.m0_done   = done_q[0];
  assign bus.m1_done   = done_q[1];
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_selevy_mem_arbiter.sv
// Directed bench for selevy_mem_arbiter with a transaction-level reference model and bench RAM.
`timescale 1ns/1ps
module tb_selevy_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  always #5 CLK = ~CLK;

  selevy_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  selevy_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (.CLK(CLK), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 5) ? 32'hDEADBEEF : 32'hA5000000 + i * 32'h00010101;
  endfunction

  // Bench RAM: synchronous read, data one cycle after the strobe.
  logic [DW-1:0] ram [256];
  initial for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
  always @(posedge CLK) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= ram[bus.ram_addr];
    end
  end

  // Reference model: ph counts the cycles of the access in flight (0 = none).
  int            ph = 0;
  int            cp = 0;
  int            pref = 0;
  bit            cwe;
  logic [AW-1:0] ca;
  logic [DW-1:0] cwd;
  logic [DW-1:0] erd;
  logic [DW-1:0] ref_mem [256];
  initial for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      ph = 0;
      pref = 0;
    end else if (ph == 0) begin
      if (bus.m0_req || bus.m1_req) begin
        cp  = (bus.m0_req && bus.m1_req) ? pref : (bus.m1_req ? 1 : 0);
        cwe = (cp == 1) ? bus.m1_we : bus.m0_we;
        ca  = (cp == 1) ? bus.m1_addr : bus.m0_addr;
        cwd = (cp == 1) ? bus.m1_wdata : bus.m0_wdata;
        ph  = 1;
      end
    end else if (ph == 1) begin
      if (cwe) ref_mem[ca] = cwd;
      else     erd = ref_mem[ca];
      ph = 2;
    end else begin
      pref = 1 - cp;
      ph = 0;
    end
  end

  int cyc = 0;
  int gnt_log[$];
  int done_cyc[$];
  int we_cnt = 0;
  int m0_done_cnt = 0;
  int m1_gnt_cnt = 0;

  always @(negedge CLK) begin
    cyc++;
    if (reset) begin
      chk("rst_m0_gnt", bus.m0_gnt, 0);   chk("rst_m1_gnt", bus.m1_gnt, 0);
      chk("rst_m0_done", bus.m0_done, 0); chk("rst_m1_done", bus.m1_done, 0);
      chk("rst_ram_en", bus.ram_en, 0);   chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_ram_addr", bus.ram_addr, 0); chk("rst_ram_wdata", bus.ram_wdata, 0);
      chk("rst_rdata", bus.rdata, 0);     chk("rst_busy", bus.busy, 0);
    end else begin
      chk("m0_gnt", bus.m0_gnt, ph == 1 && cp == 0);
      chk("m1_gnt", bus.m1_gnt, ph == 1 && cp == 1);
      chk("m0_done", bus.m0_done, ph == 2 && cp == 0);
      chk("m1_done", bus.m1_done, ph == 2 && cp == 1);
      chk("ram_en", bus.ram_en, ph == 1);
      chk("ram_we", bus.ram_we, ph == 1 && cwe);
      chk("busy", bus.busy, ph != 0);
      chk("rdata", bus.rdata, (ph == 2 && !cwe) ? erd : '0);
      if (ph == 1) begin
        chk("ram_addr", bus.ram_addr, ca);
        chk("ram_wdata", bus.ram_wdata, cwd);
      end
    end
    if (bus.m0_gnt) gnt_log.push_back(0);
    if (bus.m1_gnt) begin gnt_log.push_back(1); m1_gnt_cnt++; end
    if (bus.m0_done || bus.m1_done) done_cyc.push_back(cyc);
    if (bus.m0_done) m0_done_cnt++;
    if (bus.ram_we) we_cnt++;
  end

  // Single access on one port; entered just after a clock edge with the arbiter idle.
  task automatic single(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        output logic [DW-1:0] rd, output int lg, output int ld);
    lg = -1; ld = -1; rd = '0;
    if (p) begin bus.m1_req = 1; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = wd; end
    else   begin bus.m0_req = 1; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = wd; end
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if ((p ? bus.m1_gnt : bus.m0_gnt) && lg < 0) lg = c;
      if (p ? bus.m1_done : bus.m0_done) begin ld = c; rd = bus.rdata; break; end
    end
    @(posedge CLK); #1;
    if (p) bus.m1_req = 0; else bus.m0_req = 0;
  endtask

  // m0 reads from 16+k, m1 writes to 32+k; each re-raises its request after every done.
  task automatic run_both(input int n0, input int n1);
    int l0, l1, k0, k1, t;
    bit d0, d1;
    l0 = n0; l1 = n1; k0 = 0; k1 = 0; t = 0;
    bus.m0_req = (l0 > 0); bus.m0_we = 0; bus.m0_addr = AW'(16);
    bus.m1_req = (l1 > 0); bus.m1_we = 1; bus.m1_addr = AW'(32); bus.m1_wdata = 32'hC0DE0000;
    while ((l0 > 0 || l1 > 0) && t < 100) begin
      @(negedge CLK); d0 = bus.m0_done; d1 = bus.m1_done;
      @(posedge CLK); #1; t++;
      if (d0) begin l0--; k0++; bus.m0_req = (l0 > 0); bus.m0_addr = AW'(16 + k0); end
      if (d1) begin
        l1--; k1++; bus.m1_req = (l1 > 0);
        bus.m1_addr = AW'(32 + k1); bus.m1_wdata = 32'hC0DE0000 + k1;
      end
    end
    chk("run_both_complete", (l0 > 0 || l1 > 0), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    int lg, ld, g0, d0, snap, snap2, lat;
    bit found;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    #1 reset = 1;
    @(negedge CLK); @(negedge CLK); #2 reset = 0;
    @(posedge CLK); #1;

    // Read of preloaded word
    snap = m1_gnt_cnt;
    single(0, 0, AW'(5), '0, rd, lg, ld);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_gnt_lat", lg, 2);
    chk("t1_done_lat", ld, 3);
    chk("t1_m1_idle", m1_gnt_cnt - snap, 0);

    // Write from m1, read back from m0
    snap = we_cnt;
    single(1, 1, AW'(3), 32'h12345678, rd, lg, ld);
    chk("t2_wr_rdata", rd, 0);
    chk("t2_wr_done_lat", ld, 3);
    single(0, 0, AW'(3), '0, rd, lg, ld);
    chk("t2_rd_rdata", rd, 32'h12345678);
    chk("t2_we_cycles", we_cnt - snap, 1);

    // Reset, then both ports contending: strict alternation from m0
    #1 reset = 1;
    @(negedge CLK); #2 reset = 0;
    @(posedge CLK); #1;
    g0 = gnt_log.size(); d0 = done_cyc.size();
    run_both(4, 4);
    chk("t3_gnt_count", gnt_log.size() - g0, 8);
    if (gnt_log.size() >= g0 + 8)
      for (int k = 0; k < 8; k++) chk($sformatf("t3_gnt_order[%0d]", k), gnt_log[g0 + k], k % 2);
    if (done_cyc.size() >= d0 + 8)
      for (int k = 1; k < 8; k++) chk("t3_done_spacing", done_cyc[d0 + k] - done_cyc[d0 + k - 1], 3);

    // m0 alone back-to-back, then a tie must go to m1
    g0 = gnt_log.size(); d0 = done_cyc.size();
    run_both(3, 0);
    chk("t4_gnt_count", gnt_log.size() - g0, 3);
    if (done_cyc.size() >= d0 + 3)
      for (int k = 1; k < 3; k++) chk("t4_done_spacing", done_cyc[d0 + k] - done_cyc[d0 + k - 1], 3);
    g0 = gnt_log.size();
    run_both(1, 1);
    if (gnt_log.size() >= g0 + 2) begin
      chk("t4_tie_first", gnt_log[g0], 1);
      chk("t4_tie_second", gnt_log[g0 + 1], 0);
    end else chk("t4_tie_count", gnt_log.size() - g0, 2);

    // Reset during ISSUE of an m0 read; pending m1 served after release
    @(posedge CLK); #1;
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = AW'(5);
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (bus.m0_gnt) begin found = 1; break; end
    end
    chk("t5_gnt_seen", found, 1);
    #2 reset = 1;
    bus.m0_req = 0;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = AW'(9);
    #1;
    chk("t5_m0_gnt", bus.m0_gnt, 0);
    chk("t5_ram_en", bus.ram_en, 0);
    chk("t5_ram_addr", bus.ram_addr, 0);
    chk("t5_busy", bus.busy, 0);
    snap = m0_done_cnt;
    @(negedge CLK); #2 reset = 0;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (bus.m1_gnt) begin lat = c; break; end
    end
    chk("t5_m1_gnt_lat", lat, 1);
    @(negedge CLK);
    chk("t5_m1_done", bus.m1_done, 1);
    chk("t5_m1_rdata", bus.rdata, 32'hA5090909);
    @(posedge CLK); #1 bus.m1_req = 0;
    chk("t5_no_m0_done", m0_done_cnt - snap, 0);

    // m1 pulses its request during m0's ISSUE and is never granted
    snap2 = m1_gnt_cnt;
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = AW'(6);
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (bus.m0_gnt) begin found = 1; break; end
    end
    chk("t6_gnt_seen", found, 1);
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = AW'(10);
    @(negedge CLK);
    chk("t6_m0_done", bus.m0_done, 1);
    bus.m1_req = 0;
    @(posedge CLK); #1 bus.m0_req = 0;
    repeat (3) @(negedge CLK);
    chk("t6_busy_low", bus.busy, 0);
    chk("t6_m1_never_granted", m1_gnt_cnt - snap2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
